cordic_iter: RTL and testbench
==============================

CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter ITER SHALL default to 12 and set the number of micro-rotations (legal range 1..12).
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port valid_in, input, 1 bit: operands present this cycle; driven by the init stage's valid output.
REQ-006 Port select, input, 4 bits: bit 3 = 1 selects vectoring (arctan), bit 3 = 0 selects rotation (sin/cos); bits 2..0 are ignored.
REQ-007 Port x_in, input, 24 bits: signed X operand (rotation: 0x000100 = 1.0 in Q.8; vectoring: integer x).
REQ-008 Port y_in, input, 24 bits: signed Y operand.
REQ-009 Port z_in, input, 24 bits: signed angle in Q16.8 degrees.
REQ-010 Port ready, output, 1 bit: high when the state is IDLE.
REQ-011 Ports x_out, y_out and z_out, outputs, 24 bits each: signed results after gain compensation (z_out is not compensated).
REQ-012 Port valid_out, output, 1 bit: one-cycle result strobe.
REQ-013 Port mode_out, output, 1 bit: select[3] latched for the result on the bus.
REQ-014 Port err_out, output, 1 bit: rotation angle was out of range; valid together with valid_out.
REQ-015 Port overrun, output, 1 bit: sticky flag, set when valid_in is dropped while busy.

Function
REQ-016 The FSM SHALL have three states, IDLE, ITER and COMP, with transitions IDLE->ITER->COMP->IDLE.
REQ-017 In IDLE, valid_in=1 SHALL capture x_in, y_in and z_in, sign-extended to 26-bit internal registers, latch select[3], clear counter i to 0, and enter ITER.
REQ-018 In ITER, each cycle SHALL perform micro-rotation i and then increment i; after i = ITER-1 the FSM SHALL enter COMP.
REQ-019 In rotation mode, d SHALL be +1 if z >= 0, else -1.
REQ-020 In vectoring mode, d SHALL be +1 if y < 0, else -1.
REQ-021 Each micro-rotation SHALL compute: x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATAN[i], using arithmetic shifts and 26-bit two's-complement arithmetic.
REQ-022 ATAN[0..11] (Q.8 degrees) SHALL equal 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7.
REQ-023 In COMP, x_out SHALL equal (x*155)>>>8 and y_out SHALL equal (y*155)>>>8, each saturated to the signed 24-bit range.
REQ-024 In COMP, z_out SHALL equal z saturated to 24 bits, valid_out SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-025 Latency: valid_in sampled at edge N SHALL produce valid_out high in the cycle following edge N+ITER+1 (13 cycles for ITER=12).
REQ-026 The earliest next acceptance SHALL be edge N+ITER+2, giving one result per 14 cycles at ITER=12.
REQ-027 Outputs SHALL hold their values between valid_out strobes.
REQ-028 err_out SHALL be 1 when rotation mode is selected and |z_in| > 23040 (90.0 degrees); the computation SHALL proceed normally.
REQ-029 err_out SHALL always be 0 in vectoring mode.
REQ-030 valid_in=1 in ITER or COMP SHALL be ignored and SHALL set overrun; overrun SHALL clear only on reset.
REQ-031 valid_in=1 in the same cycle as the COMP-state valid_out strobe SHALL NOT be accepted.
REQ-032 valid_in=1 in the cycle after the strobe (FSM back in IDLE) SHALL be accepted.
REQ-033 In vectoring mode, x_in < 0 is outside contract; the result is undefined but the FSM SHALL still return to IDLE.

Reset
REQ-034 When rst_n is low, the FSM SHALL go to IDLE and i SHALL clear to 0, immediately and asynchronously.
REQ-035 Reset SHALL force x_out, y_out, z_out, valid_out, mode_out, err_out and overrun to 0, and ready to 1.
REQ-036 Reset asserted mid-operation SHALL discard the operation with no valid_out.
REQ-037 After rst_n deasserts, the first clock edge with valid_in=1 SHALL be accepted.

Verification
REQ-038 Rotation case: select=0, x=0x000100, y=0, z=0 -> 13 cycles later valid_out=1, x_out=256+/-3, y_out=0+/-3, z_out=0+/-8, err_out=0.
REQ-039 Rotation at 90 degrees: z=0x005A00, x=0x000100 -> x_out=0+/-3, y_out=256+/-3, err_out=0; repeat with z=0x005B00 -> err_out=1.
REQ-040 Vectoring case: select=4'b1000, x=3, y=4, z=0 -> x_out=5+/-1, y_out=0+/-1, z_out=13601+/-8, mode_out=1.
REQ-041 Overrun case: valid_in pulsed 5 cycles after an accepted request -> first result unchanged, overrun=1 and held, no second valid_out.
REQ-042 Reset case: rst_n pulsed low during iteration 6 -> all outputs 0 at once, no valid_out; a new request issued after release completes in 13 cycles.
REQ-043 Throughput case: valid_in held high with a vector changing every cycle -> acceptances exactly 14 cycles apart, each result matching the operand captured at its acceptance edge.

Source files
------------

// File: rtl/cordic_iter.sv
// rtl/cordic_iter.sv - iterative CORDIC engine, rotation (sin/cos) and vectoring (arctan)
// One micro-rotation per clock; gain is compensated by 155/256 on the way out.
module cordic_iter #(
  parameter int ITER = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [3:0]  select,
  input  logic [23:0] x_in,
  input  logic [23:0] y_in,
  input  logic [23:0] z_in,
  output logic        ready,
  output logic [23:0] x_out,
  output logic [23:0] y_out,
  output logic [23:0] z_out,
  output logic        valid_out,
  output logic        mode_out,
  output logic        err_out,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP} state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t             state_q, state_d;
  logic [3:0]         i_q, i_d;
  logic signed [25:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic [23:0]        x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic               valid_q, valid_d;
  logic               mode_out_q, mode_out_d;
  logic               err_out_q, err_out_d;
  logic               ovr_q, ovr_d;

  logic signed [25:0] x_sh, y_sh, atan_i;
  logic               d_pos;
  logic signed [34:0] x_prod, y_prod;
  logic               sel_unused;

  assign sel_unused = ^select[2:0];

  function automatic logic signed [25:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 26'sd11520;
      4'd1:    atan_lut = 26'sd6801;
      4'd2:    atan_lut = 26'sd3593;
      4'd3:    atan_lut = 26'sd1824;
      4'd4:    atan_lut = 26'sd916;
      4'd5:    atan_lut = 26'sd458;
      4'd6:    atan_lut = 26'sd229;
      4'd7:    atan_lut = 26'sd115;
      4'd8:    atan_lut = 26'sd57;
      4'd9:    atan_lut = 26'sd29;
      4'd10:   atan_lut = 26'sd14;
      4'd11:   atan_lut = 26'sd7;
      default: atan_lut = 26'sd0;
    endcase
  endfunction

  function automatic logic [23:0] sat24(input logic signed [26:0] v);
    if (v > 27'sd8388607)
      sat24 = 24'h7FFFFF;
    else if (v < -27'sd8388608)
      sat24 = 24'h800000;
    else
      sat24 = v[23:0];
  endfunction

  // Rotation drives z toward 0; vectoring drives y toward 0.
  assign d_pos  = mode_q ? y_q[25] : ~z_q[25];
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_i = atan_lut(i_q);
  assign x_prod = $signed({{9{x_q[25]}}, x_q}) * 35'sd155;
  assign y_prod = $signed({{9{y_q[25]}}, y_q}) * 35'sd155;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    mode_d     = mode_q;
    err_d      = err_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    z_out_d    = z_out_q;
    valid_d    = 1'b0;
    mode_out_d = mode_out_q;
    err_out_d  = err_out_q;
    ovr_d      = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          x_d     = {{2{x_in[23]}}, x_in};
          y_d     = {{2{y_in[23]}}, y_in};
          z_d     = {{2{z_in[23]}}, z_in};
          mode_d  = select[3];
          err_d   = ~select[3] &&
                    (($signed(z_in) > 24'sd23040) || ($signed(z_in) < -24'sd23040));
          i_d     = 4'd0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (d_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        i_d = i_q + 4'd1;
        if (i_q == LAST) state_d = S_COMP;
        if (valid_in) ovr_d = 1'b1;
      end
      S_COMP: begin
        x_out_d    = sat24($signed(x_prod[34:8]));
        y_out_d    = sat24($signed(y_prod[34:8]));
        z_out_d    = sat24({z_q[25], z_q});
        mode_out_d = mode_q;
        err_out_d  = err_q;
        valid_d    = 1'b1;
        state_d    = S_IDLE;
        if (valid_in) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= 4'd0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      z_out_q    <= '0;
      valid_q    <= 1'b0;
      mode_out_q <= 1'b0;
      err_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      z_out_q    <= z_out_d;
      valid_q    <= valid_d;
      mode_out_q <= mode_out_d;
      err_out_q  <= err_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign valid_out = valid_q;
  assign mode_out  = mode_out_q;
  assign err_out   = err_out_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_cordic_iter.sv
// tb/tb_cordic_iter.sv - scoreboard bench for cordic_iter against an arithmetic CORDIC model
module tb_cordic_iter;

  localparam int ITER = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [3:0]  select;
  logic [23:0] x_in, y_in, z_in;
  logic        ready;
  logic [23:0] x_out, y_out, z_out;
  logic        valid_out, mode_out, err_out, overrun;

  cordic_iter #(.ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .select(select),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .ready(ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .valid_out(valid_out),
    .mode_out(mode_out), .err_out(err_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] x;
    logic [23:0] y;
    logic [23:0] z;
    logic        mode;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   next_free = 0;
  logic ovr_exp = 1'b0;
  int   atan_tab[12] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic longint w26(input longint v);
    longint m;
    m = v & 64'h3FFFFFF;
    if (m[25]) m = m - 64'h4000000;
    return m;
  endfunction

  function automatic logic [23:0] sat24(input longint v);
    if (v > 8388607) return 24'h7FFFFF;
    if (v < -8388608) return 24'h800000;
    return v[23:0];
  endfunction

  function automatic exp_t model(input logic md, input logic [23:0] xi, yi, zi);
    exp_t   e;
    longint x, y, z, z0, d, nx, ny, nz;
    x  = longint'($signed(xi));
    y  = longint'($signed(yi));
    z  = longint'($signed(zi));
    z0 = z;
    for (int i = 0; i < ITER; i++) begin
      if (md) d = (y < 0) ? 1 : -1;
      else    d = (z >= 0) ? 1 : -1;
      nx = w26(x - d * (y >>> i));
      ny = w26(y + d * (x >>> i));
      nz = w26(z - d * atan_tab[i]);
      x = nx; y = ny; z = nz;
    end
    e.x    = sat24((x * 155) >>> 8);
    e.y    = sat24((y * 155) >>> 8);
    e.z    = sat24(z);
    e.mode = md;
    e.err  = !md && (z0 > 23040 || z0 < -23040);
    e.cyc  = 0;
    return e;
  endfunction

  // Scoreboard monitor: pops on every strobe, otherwise outputs must hold.
  exp_t last = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last = '0;
      check("reset_outputs", {x_out, y_out, z_out, mode_out, err_out, valid_out, overrun, ready},
            {72'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    end else if (valid_out) begin
      if (q.size() == 0) begin
        check("unexpected_valid_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        check("x_out", x_out, e.x);
        check("y_out", y_out, e.y);
        check("z_out", z_out, e.z);
        check("mode_out", mode_out, e.mode);
        check("err_out", err_out, e.err);
        last = e;
      end
    end else begin
      check("hold", {x_out, y_out, z_out, mode_out, err_out},
            {last.x, last.y, last.z, last.mode, last.err});
    end
  end

  task automatic drive(input logic v, input logic [3:0] sel, input logic [23:0] x, y, z);
    int   e;
    logic ovr_pend;
    exp_t ev;
    @(negedge clk);
    valid_in = v; select = sel; x_in = x; y_in = y; z_in = z;
    e = cyc + 1;
    ovr_pend = 1'b0;
    check("ready", ready, (e >= next_free));
    if (v) begin
      if (e >= next_free) begin
        ev = model(sel[3], x, y, z);
        ev.cyc = e + ITER + 1;
        q.push_back(ev);
        next_free = e + ITER + 2;
      end else begin
        ovr_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (ovr_pend) ovr_exp = 1'b1;
    check("overrun", overrun, ovr_exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'd0, 24'd0, 24'd0, 24'd0);
  endtask

  task automatic run_one(input logic [3:0] sel, input logic [23:0] x, y, z,
                         output logic [23:0] rx, ry, rz, output logic rm, re);
    int n;
    drive(1'b1, sel, x, y, z);
    n = 0;
    while (valid_out !== 1'b1 && n < 40) begin
      drive(1'b0, sel, x, y, z);
      n++;
    end
    if (n >= 40) check("result_timeout", 1, 0);
    rx = x_out; ry = y_out; rz = z_out; rm = mode_out; re = err_out;
    idle(1);
  endtask

  task automatic rand_vec(output logic [3:0] sel, output logic [23:0] x, y, z);
    logic md;
    md  = 1'($urandom);
    sel = {md, 3'($urandom)};
    if ($urandom_range(0, 7) == 0) begin
      x = 24'($urandom); y = 24'($urandom); z = 24'($urandom);
      if (md) x[23] = 1'b0;
    end else begin
      x = md ? 24'($urandom_range(0, 8000)) : 24'(int'($urandom_range(0, 4000)) - 2000);
      y = 24'(int'($urandom_range(0, 4000)) - 2000);
      z = md ? 24'd0 : 24'(int'($urandom_range(0, 60000)) - 30000);
    end
  endtask

  initial begin
    logic [23:0] rx, ry, rz, x, y, z;
    logic        rm, re;
    logic [3:0]  sel;
    int          n;
    rst_n = 1'b1; valid_in = 1'b0; select = '0; x_in = '0; y_in = '0; z_in = '0;
    #1 rst_n = 1'b0;
    #1 check("reset_ready", ready, 1'b1);
    check("reset_valid", {valid_out, overrun, x_out}, 26'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    next_free = cyc + 1;

    run_one(4'b0000, 24'h000100, 24'h0, 24'h0, rx, ry, rz, rm, re);
    check("rot0_err", re, 1'b0);
    run_one(4'b0000, 24'h000100, 24'h0, 24'h005A00, rx, ry, rz, rm, re);
    check("rot90_err", re, 1'b0);
    run_one(4'b0000, 24'h000100, 24'h0, 24'h005B00, rx, ry, rz, rm, re);
    check("rot91_err", re, 1'b1);
    run_one(4'b0111, 24'h000100, 24'h0, 24'hFFA500, rx, ry, rz, rm, re);
    check("rotm91_err", re, 1'b1);
    run_one(4'b1000, 24'd3, 24'd4, 24'd0, rx, ry, rz, rm, re);
    check("vec_mode", rm, 1'b1);
    check("vec_err", re, 1'b0);
    check("vec_x_range", ($signed(rx) >= 4 && $signed(rx) <= 6), 1'b1);
    check("vec_y_range", ($signed(ry) >= -1 && $signed(ry) <= 1), 1'b1);

    // Overrun: pulse 5 cycles after acceptance; only one result may appear.
    drive(1'b1, 4'b0000, 24'h000100, 24'h000080, 24'h001000);
    idle(4);
    drive(1'b1, 4'b1000, 24'd99, 24'd99, 24'd0);
    idle(30);
    check("overrun_sticky", overrun, 1'b1);

    // Reset during iteration 6 discards the operation.
    drive(1'b1, 4'b0000, 24'h000100, 24'h0, 24'h002000);
    idle(6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_ready", ready, 1'b1);
    check("midreset_outs", {x_out, y_out, z_out, valid_out, mode_out, err_out, overrun}, 78'd0);
    q.delete();
    ovr_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_free = cyc + 1;
    run_one(4'b0000, 24'h000100, 24'h0, 24'h001680, rx, ry, rz, rm, re);
    check("post_reset_err", re, 1'b0);

    // Throughput: valid_in held high with a new vector every cycle.
    for (int k = 0; k < 60; k++) begin
      rand_vec(sel, x, y, z);
      drive(1'b1, sel, x, y, z);
    end

    for (int k = 0; k < 300; k++) begin
      rand_vec(sel, x, y, z);
      drive(($urandom_range(0, 3) == 0), sel, x, y, z);
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin
      idle(1);
      n++;
    end
    check("drain", 64'(q.size()), 0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
